epmp_debug_ctrl: RTL

Run/step controller for the EPMP processor; sits directly upstream of the control unit and drives its `Debug_Run` and `Debug_Mode` inputs from front-panel buttons and a mode switch. It synchronises and conditions the raw button inputs and holds a HALT/RUN/STEP state machine. It also counts executed instructions by watching the control unit's `Debug_State` output.

---
 rtl/epmp_debug_ctrl_pkg.sv | 33 +++
 rtl/epmp_btn_cond.sv | 62 ++++++
 rtl/epmp_debug_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/epmp_debug_ctrl_pkg.sv
// Shared encodings for the EPMP debug controller: control-unit states,
// debug-mode constants and the run/step FSM states.
package epmp_debug_ctrl_pkg;

  localparam logic [4:0] StReset  = 5'd0;
  localparam logic [4:0] StFetch0 = 5'd1;
  localparam logic [4:0] StFetch1 = 5'd2;
  localparam logic [4:0] StFetch2 = 5'd3;
  localparam logic [4:0] StDecode = 5'd4;
  localparam logic [4:0] StExec   = 5'd5;
  localparam logic [4:0] StRead   = 5'd6;
  localparam logic [4:0] StWrite  = 5'd7;
  localparam logic [4:0] StHalt   = 5'd8;

  typedef enum logic [1:0] {
    DBG_CONT  = 2'd0,
    DBG_ISTEP = 2'd1,
    DBG_MSTEP = 2'd2,
    DBG_USTEP = 2'd3
  } dbg_mode_e;

  typedef enum logic [1:0] {
    FSM_HALT = 2'd0,
    FSM_RUN  = 2'd1,
    FSM_STEP = 2'd2
  } fsm_state_e;

  // An instruction is counted on entry into StFetch0, not while it lingers there.
  function automatic logic is_fetch_start(input logic [4:0] cur, input logic [4:0] prev);
    return (cur == StFetch0) && (prev != StFetch0);
  endfunction

endpackage

// File: rtl/epmp_btn_cond.sv
// Button conditioner: 2-flop synchroniser, optional debouncer
// (EPMP_DBG_DEBOUNCE_EN) and registered rising-edge detector.
module epmp_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic Reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic [1:0] sync_q;
  logic       level_s;
  logic       prev_q;
  logic       pulse_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

`ifdef EPMP_DBG_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic          stable_q;
  logic [CW-1:0] cnt_q;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (Reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else if (sync_q[1] == stable_q) begin
      cnt_q    <= '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_q <= sync_q[1];
      cnt_q    <= '0;
    end else begin
      cnt_q    <= cnt_q + CW'(1);
    end
  end

  assign level_s = stable_q;
`else
  assign level_s = sync_q[1];
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= level_s;
      pulse_q <= level_s & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/epmp_debug_ctrl.sv
// EPMP run/step debug controller with instruction counter.
// Build with EPMP_DBG_DEBOUNCE_EN to insert button debouncers.
module epmp_debug_ctrl
  import epmp_debug_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Btn_Run,
  input  logic             Btn_Step,
  input  logic [1:0]       Mode_Sel,
  input  logic [4:0]       Debug_State,
  output logic             Debug_Run,
  output logic [1:0]       Debug_Mode,
  output logic             Halted,
  output logic [CNT_W-1:0] Instr_Count
);

  logic       run_p;
  logic       step_p;
  fsm_state_e state_q;
  logic       run_q;
  logic [1:0] mode_q;
  logic       halted_q;

  logic [4:0]       prev_state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  epmp_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_cond (
    .clk     (clk),
    .Reset   (Reset),
    .btn_i   (Btn_Run),
    .pulse_o (run_p)
  );

  epmp_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_cond (
    .clk     (clk),
    .Reset   (Reset),
    .btn_i   (Btn_Step),
    .pulse_o (step_p)
  );

  // Mode is sampled only while halted so a running program keeps its granularity.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= FSM_HALT;
      run_q    <= 1'b0;
      mode_q   <= 2'd0;
      halted_q <= 1'b1;
    end else begin
      case (state_q)
        FSM_HALT: begin
          mode_q <= Mode_Sel;
          if (run_p) begin
            state_q  <= FSM_RUN;
            run_q    <= 1'b1;
            halted_q <= 1'b0;
          end else if (step_p) begin
            state_q  <= FSM_STEP;
            run_q    <= 1'b1;
            halted_q <= 1'b0;
          end else begin
            state_q  <= FSM_HALT;
            run_q    <= 1'b0;
            halted_q <= 1'b1;
          end
        end
        FSM_RUN: begin
          if (run_p) begin
            state_q  <= FSM_HALT;
            run_q    <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q  <= FSM_RUN;
            run_q    <= 1'b1;
            halted_q <= 1'b0;
          end
        end
        FSM_STEP: begin
          state_q  <= FSM_HALT;
          run_q    <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= FSM_HALT;
          run_q    <= 1'b0;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (is_fetch_start(Debug_State, prev_state_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      prev_state_q <= StReset;
      cnt_q        <= '0;
    end else begin
      prev_state_q <= Debug_State;
      cnt_q        <= cnt_d;
    end
  end

  assign Debug_Run   = run_q;
  assign Debug_Mode  = mode_q;
  assign Halted      = halted_q;
  assign Instr_Count = cnt_q;

endmodule
